// File: rtl/count_display_driver_if.sv
// Bundle between the mod-N counter and the display driver: count value in,
// segment/anode drive plus the committed BCD result out.
interface count_display_driver_if #(
  parameter int unsigned W      = 4,
  parameter int unsigned DIGITS = 2
);
  logic [W-1:0]          value;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (output value, input seg, dp, an, bcd, ovf);
  modport slave  (input value, output seg, dp, an, bcd, ovf);
endinterface

// File: rtl/count_display_driver.sv
// Shows a binary count in decimal on a multiplexed 7-segment display using a
// free-running sequential double-dabble converter and a digit-scan timer.
module count_display_driver #(
  parameter int unsigned W           = 4,
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter bit          LZB         = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  count_display_driver_if.slave bus
);

  // One guard nibble above the displayed digits keeps overflow out of the low digits.
  localparam int unsigned BcdW = 4 * (DIGITS + 1);
  localparam int unsigned CntW = $clog2(W + 1);
  localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam longint unsigned Limit = 64'd10 ** DIGITS;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [W-1:0]        sh_q, sh_d;
  logic [W-1:0]        cap_q, cap_d;
  logic [BcdW-1:0]     work_q, work_d;
  logic [CntW-1:0]     iter_q, iter_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;

  logic [BcdW-1:0]     adj;
  logic [BcdW+W-1:0]   shifted;

  always_comb begin
    adj = work_q;
    for (int i = 0; i < int'(DIGITS) + 1; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj, sh_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cap_d   = cap_q;
    work_d  = work_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        sh_d    = bus.value;
        cap_d   = bus.value;
        work_d  = '0;
        iter_d  = CntW'(W);
        state_d = StShift;
      end
      StShift: begin
        {work_d, sh_d} = shifted;
        iter_d         = iter_q - CntW'(1);
        if (iter_q == CntW'(1)) state_d = StDone;
      end
      StDone: begin
        bcd_d   = work_q[4*DIGITS-1:0];
        ovf_d   = (64'(cap_q) >= Limit);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cap_q   <= '0;
      work_q  <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cap_q   <= cap_d;
      work_q  <= work_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  logic [RefW-1:0] ref_q, ref_d;
  logic [IdxW-1:0] idx_q, idx_d;

  always_comb begin
    ref_d = ref_q + RefW'(1);
    idx_d = idx_q;
    if (ref_q == RefW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

  logic [IdxW-1:0]   top_nz;
  logic [3:0]        nib;
  logic [6:0]        glyph;
  logic [6:0]        digit_seg;
  logic [DIGITS-1:0] an_act;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  always_comb begin
    top_nz = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) top_nz = IdxW'(i);
    end
    nib = bcd_q[{idx_q, 2'b00} +: 4];
    case (nib)
      4'd0:    digit_seg = 7'b0111111;
      4'd1:    digit_seg = 7'b0000110;
      4'd2:    digit_seg = 7'b1011011;
      4'd3:    digit_seg = 7'b1001111;
      4'd4:    digit_seg = 7'b1100110;
      4'd5:    digit_seg = 7'b1101101;
      4'd6:    digit_seg = 7'b1111101;
      4'd7:    digit_seg = 7'b0000111;
      4'd8:    digit_seg = 7'b1111111;
      4'd9:    digit_seg = 7'b1101111;
      default: digit_seg = 7'b0000000;
    endcase
    if (ovf_q) begin
      glyph = 7'b1000000;
    end else if (LZB && (idx_q > top_nz)) begin
      glyph = 7'b0000000;
    end else begin
      glyph = digit_seg;
    end
    an_act        = '0;
    an_act[idx_q] = 1'b1;
    seg_d = ACTIVE_LOW ? ~glyph : glyph;
    an_d  = ACTIVE_LOW ? ~an_act : an_act;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      idx_q <= '0;
      seg_q <= {7{ACTIVE_LOW}};
      an_q  <= {DIGITS{ACTIVE_LOW}};
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = ACTIVE_LOW;
  assign bus.bcd = bcd_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Bench for count_display_driver: several parameterisations side by side, a
// scoreboard of expected conversions and a vector table for the W=4 instance.
module tb_count_display_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  count_display_driver_if #(.W(4), .DIGITS(2)) if0 ();
  count_display_driver_if #(.W(6), .DIGITS(2)) if1 ();
  count_display_driver_if #(.W(6), .DIGITS(2)) if2 ();
  count_display_driver_if #(.W(7), .DIGITS(2)) if3 ();
  count_display_driver_if #(.W(4), .DIGITS(3)) if4 ();

  count_display_driver #(.W(4), .DIGITS(2), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1), .LZB(1'b1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  count_display_driver #(.W(6), .DIGITS(2), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1), .LZB(1'b1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  count_display_driver #(.W(6), .DIGITS(2), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1), .LZB(1'b0))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  count_display_driver #(.W(7), .DIGITS(2), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1), .LZB(1'b1))
    u3 (.clk(clk), .rst(rst), .bus(if3));
  count_display_driver #(.W(4), .DIGITS(3), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1), .LZB(1'b1))
    u4 (.clk(clk), .rst(rst), .bus(if4));

  logic [6:0]  seg_m [5];
  logic [2:0]  an_m  [5];
  logic [11:0] bcd_m [5];
  logic        ovf_m [5];

  assign seg_m[0] = if0.seg;  assign an_m[0] = {1'b0, if0.an};
  assign seg_m[1] = if1.seg;  assign an_m[1] = {1'b0, if1.an};
  assign seg_m[2] = if2.seg;  assign an_m[2] = {1'b0, if2.an};
  assign seg_m[3] = if3.seg;  assign an_m[3] = {1'b0, if3.an};
  assign seg_m[4] = if4.seg;  assign an_m[4] = if4.an;
  assign bcd_m[0] = {4'h0, if0.bcd};  assign ovf_m[0] = if0.ovf;
  assign bcd_m[1] = {4'h0, if1.bcd};  assign ovf_m[1] = if1.ovf;
  assign bcd_m[2] = {4'h0, if2.bcd};  assign ovf_m[2] = if2.ovf;
  assign bcd_m[3] = {4'h0, if3.bcd};  assign ovf_m[3] = if3.ovf;
  assign bcd_m[4] = if4.bcd;          assign ovf_m[4] = if4.ovf;

  typedef struct {
    int          inst;
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [3:0] value;
    logic [7:0] bcd;
    logic [6:0] seg1;
    logic [6:0] seg0;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int inst, input logic [11:0] b, input logic o);
    exp_t e;
    e.inst = inst;
    e.bcd  = b;
    e.ovf  = o;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got empty scoreboard, want an entry", name);
    end else begin
      e = sb.pop_front();
      check({name, ".bcd"}, 32'(bcd_m[e.inst]), 32'(e.bcd));
      check({name, ".ovf"}, 32'(ovf_m[e.inst]), 32'(e.ovf));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) until the given anode pattern is shown, then checks its segments.
  task automatic seg_on_digit(input string name, input int inst, input logic [2:0] an_pat,
                              input logic [6:0] seg_exp);
    int i;
    i = 0;
    while (an_m[inst] !== an_pat && i < 40) begin
      @(negedge clk);
      i++;
    end
    check({name, ".an"}, 32'(an_m[inst]), 32'(an_pat));
    check({name, ".seg"}, 32'(seg_m[inst]), 32'(seg_exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] an_exp;
    int         idx;

    vecs[0] = '{4'd0,  8'h00, 7'h7F, 7'h40};
    vecs[1] = '{4'd9,  8'h09, 7'h7F, 7'h10};
    vecs[2] = '{4'd10, 8'h10, 7'h79, 7'h40};
    vecs[3] = '{4'd15, 8'h15, 7'h79, 7'h12};
    vecs[4] = '{4'd12, 8'h12, 7'h79, 7'h24};
    vecs[5] = '{4'd8,  8'h08, 7'h7F, 7'h00};

    if0.value = 4'd7;
    if1.value = 6'd59;
    if2.value = 6'd3;
    if3.value = 7'd100;
    if4.value = 4'd7;

    // Reset state
    cycles(3);
    check("rst.an", 32'(an_m[0]), 32'(3'b011));
    check("rst.seg", 32'(seg_m[0]), 32'h7F);
    check("rst.bcd", 32'(bcd_m[0]), 32'h0);
    check("rst.ovf", 32'(ovf_m[0]), 32'h0);
    check("rst.dp", 32'(if0.dp), 32'h1);
    check("rst.an3", 32'(an_m[4]), 32'(3'b111));

    push(0, 12'h007, 1'b0);
    push(1, 12'h059, 1'b0);
    push(2, 12'h003, 1'b0);
    push(3, 12'h000, 1'b1);
    rst = 1'b0;

    // Edge-by-edge timeline from release: scan pattern plus conversion latency
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      idx    = (k / 4) % 2;
      an_exp = (idx == 1) ? 3'b001 : 3'b010;
      check($sformatf("scan2.e%0d", k), 32'(an_m[0]), 32'(an_exp));
      idx    = (k / 4) % 3;
      an_exp = ~(3'b001 << idx);
      check($sformatf("scan3.e%0d", k), 32'(an_m[4]), 32'(an_exp));
      if (k == 0) check("first.seg", 32'(seg_m[0]), 32'h40);
      if (k == 4) check("lat.early_bcd", 32'(bcd_m[0]), 32'h0);
      if (k == 5) pop_check("lat.w4");
      if (k == 6) check("lzb.d1_seg", 32'(seg_m[0]), 32'h7F);
      if (k == 7) begin
        pop_check("w6.v59");
        pop_check("w6.lzb0.v3");
      end
      if (k == 8) begin
        check("w4.d0_seg", 32'(seg_m[0]), 32'h78);
        pop_check("w7.v100");
      end
    end

    seg_on_digit("w6.d1", 1, 3'b001, 7'h12);
    seg_on_digit("w6.d0", 1, 3'b010, 7'h10);
    seg_on_digit("lzb0.d1", 2, 3'b001, 7'h40);
    seg_on_digit("lzb0.d0", 2, 3'b010, 7'h30);
    seg_on_digit("ovf.d1", 3, 3'b001, 7'h3F);
    seg_on_digit("ovf.d0", 3, 3'b010, 7'h3F);

    // Recovery from overflow within two sampling periods
    if3.value = 7'd42;
    push(3, 12'h042, 1'b0);
    cycles(18);
    pop_check("w7.v42");
    seg_on_digit("v42.d1", 3, 3'b001, 7'h19);
    seg_on_digit("v42.d0", 3, 3'b010, 7'h24);

    for (int i = 0; i < 6; i++) begin
      if0.value = vecs[i].value;
      push(0, {4'h0, vecs[i].bcd}, 1'b0);
      cycles(13);
      pop_check($sformatf("vec%0d", i));
      seg_on_digit($sformatf("vec%0d.d1", i), 0, 3'b001, vecs[i].seg1);
      seg_on_digit($sformatf("vec%0d.d0", i), 0, 3'b010, vecs[i].seg0);
    end

    // Value change during SHIFT is ignored until the next sample
    rst = 1'b1;
    if0.value = 4'd7;
    cycles(2);
    push(0, 12'h007, 1'b0);
    push(0, 12'h002, 1'b0);
    rst = 1'b0;
    cycles(2);
    if0.value = 4'd2;
    cycles(4);
    pop_check("midchg.first");
    cycles(5);
    check("midchg.hold", 32'(bcd_m[0]), 32'h07);
    cycles(1);
    pop_check("midchg.second");

    // Reset during SHIFT discards the partial result and restarts cleanly
    if0.value = 4'd9;
    cycles(1);
    rst = 1'b1;
    cycles(1);
    check("midrst.bcd", 32'(bcd_m[0]), 32'h0);
    check("midrst.ovf", 32'(ovf_m[0]), 32'h0);
    check("midrst.an", 32'(an_m[0]), 32'(3'b011));
    check("midrst.seg", 32'(seg_m[0]), 32'h7F);
    if0.value = 4'd5;
    push(0, 12'h005, 1'b0);
    rst = 1'b0;
    cycles(5);
    check("midrst.early", 32'(bcd_m[0]), 32'h0);
    cycles(1);
    pop_check("midrst.fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
